// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester handshake, response and RAM-port signals for ram_port_arbiter.
// The arbiter uses the slave view; requesters and the RAM model use the master view.
interface ram_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int AWIDTH  = 10,
    parameter int DWIDTH  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_wren;
    logic [NUM_REQ*AWIDTH-1:0] req_addr;
    logic [NUM_REQ*DWIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DWIDTH-1:0]         rsp_data;
    logic [AWIDTH-1:0]         ram_address;
    logic                      ram_wren;
    logic [DWIDTH-1:0]         ram_data;
    logic [DWIDTH-1:0]         ram_out;

    modport slave (
        input  req_valid, req_wren, req_addr, req_wdata, ram_out,
        output req_ready, rsp_valid, rsp_data, ram_address, ram_wren, ram_data
    );

    modport master (
        output req_valid, req_wren, req_addr, req_wdata, ram_out,
        input  req_ready, rsp_valid, rsp_data, ram_address, ram_wren, ram_data
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters; read data
// returns to the issuing requester after a fixed 1 (REG_REQ=0) or 2 (REG_REQ=1) cycles.
module ram_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AWIDTH  = 10,
    parameter int DWIDTH  = 32,
    parameter bit REG_REQ = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    ram_port_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAT   = REG_REQ ? 2 : 1;

    typedef logic [IDX_W-1:0] idx_t;

    // Explicit wrap at NUM_REQ-1 so non-power-of-two counts never reach unused ids.
    function automatic idx_t wrap_add(idx_t base, int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return idx_t'(s);
    endfunction

    idx_t               ptr_q, ptr_d;
    idx_t               grant_idx;
    logic               grant_found;
    logic               sel_wren;
    logic [AWIDTH-1:0]  sel_addr;
    logic [DWIDTH-1:0]  sel_wdata;
    logic               accept_rd;

    logic [LAT-1:0]     tag_vld_q;
    idx_t               tag_id_q [LAT];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && bus.req_valid[wrap_add(ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(ptr_q, k);
            end
        end
    end

    // With no grant grant_idx equals ptr_q, so the mux then follows the pointer.
    assign sel_wren  = bus.req_wren[grant_idx];
    assign sel_addr  = bus.req_addr[int'(grant_idx)*AWIDTH +: AWIDTH];
    assign sel_wdata = bus.req_wdata[int'(grant_idx)*DWIDTH +: DWIDTH];
    assign accept_rd = grant_found & ~sel_wren;
    assign ptr_d     = grant_found ? wrap_add(grant_idx, 1) : ptr_q;

    assign bus.req_ready = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < LAT; i++) tag_id_q[i] <= '0;
        end else begin
            ptr_q        <= ptr_d;
            tag_vld_q[0] <= accept_rd;
            tag_id_q[0]  <= grant_idx;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    assign bus.rsp_valid = tag_vld_q[LAT-1] ? (NUM_REQ'(1) << tag_id_q[LAT-1]) : '0;
    assign bus.rsp_data  = bus.ram_out;

    if (REG_REQ) begin : g_reg_req
        logic [AWIDTH-1:0] ram_addr_q;
        logic [DWIDTH-1:0] ram_data_q;
        logic              ram_wren_q;

        // NOTE: address/data are reset too; harmless here and keeps the port X-free.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ram_addr_q <= '0;
                ram_data_q <= '0;
                ram_wren_q <= 1'b0;
            end else begin
                ram_wren_q <= grant_found & sel_wren;
                if (grant_found) begin
                    ram_addr_q <= sel_addr;
                    ram_data_q <= sel_wdata;
                end
            end
        end

        assign bus.ram_address = ram_addr_q;
        assign bus.ram_data    = ram_data_q;
        assign bus.ram_wren    = ram_wren_q;
    end else begin : g_comb_req
        assign bus.ram_address = sel_addr;
        assign bus.ram_data    = sel_wdata;
        assign bus.ram_wren    = grant_found & sel_wren;
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Drives one request stream into a REG_REQ=0 and a REG_REQ=1 arbiter, each with its
// own RAM model, and scoreboards grants, RAM port activity and read responses.
module tb_ram_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct {
        int unsigned    id;
        logic [DW-1:0]  data;
        int unsigned    due;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_wren;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;

    ram_port_arbiter_if #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW)) bus0 ();
    ram_port_arbiter_if #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW)) bus1 ();

    assign bus0.req_valid = req_valid;
    assign bus0.req_wren  = req_wren;
    assign bus0.req_addr  = req_addr;
    assign bus0.req_wdata = req_wdata;
    assign bus1.req_valid = req_valid;
    assign bus1.req_wren  = req_wren;
    assign bus1.req_addr  = req_addr;
    assign bus1.req_wdata = req_wdata;

    ram_port_arbiter #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW), .REG_REQ(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    ram_port_arbiter #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW), .REG_REQ(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    // RAM models: output registered, a write leaves ram_out unchanged.
    logic [DW-1:0] mem0 [1<<AW];
    logic [DW-1:0] mem1 [1<<AW];
    always @(posedge clk) begin
        if (bus0.ram_wren) mem0[bus0.ram_address] <= bus0.ram_data;
        else               bus0.ram_out <= mem0[bus0.ram_address];
    end
    always @(posedge clk) begin
        if (bus1.ram_wren) mem1[bus1.ram_address] <= bus1.ram_data;
        else               bus1.ram_out <= mem1[bus1.ram_address];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference model state
    int unsigned   cyc = 0;
    int            mptr = 0;
    logic [DW-1:0] ref_mem [1<<AW];
    rsp_t          sb0 [$];
    rsp_t          sb1 [$];
    int            grant_log [$];
    logic          exp1_wren = 1'b0;
    logic [AW-1:0] exp1_addr = '0;
    logic [DW-1:0] exp1_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    int            g;
    int            gl;
    logic [N-1:0]  exp_rdy;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;
    rsp_t          ent;

    always @(negedge clk) begin
        if (reset) begin
            check("rsp_valid_in_reset0", 64'(bus0.rsp_valid), 64'd0);
            check("rsp_valid_in_reset1", 64'(bus1.rsp_valid), 64'd0);
            check("ram_wren_in_reset1", 64'(bus1.ram_wren), 64'd0);
            sb0.delete();
            sb1.delete();
            mptr      = 0;
            exp1_wren = 1'b0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
            exp_rdy = (g >= 0) ? oh(g) : '0;
            check("req_ready0", 64'(bus0.req_ready), 64'(exp_rdy));
            check("req_ready1", 64'(bus1.req_ready), 64'(exp_rdy));

            gl = -1;
            for (int k = 0; k < N; k++)
                if (bus0.req_ready[k] && req_valid[k]) gl = k;
            if (gl >= 0) grant_log.push_back(gl);

            if (sb0.size() > 0 && sb0[0].due == cyc) begin
                check("rsp_valid0", 64'(bus0.rsp_valid), 64'(oh(int'(sb0[0].id))));
                check("rsp_data0", 64'(bus0.rsp_data), 64'(sb0[0].data));
                void'(sb0.pop_front());
            end else begin
                check("rsp_idle0", 64'(bus0.rsp_valid), 64'd0);
            end
            if (sb1.size() > 0 && sb1[0].due == cyc) begin
                check("rsp_valid1", 64'(bus1.rsp_valid), 64'(oh(int'(sb1[0].id))));
                check("rsp_data1", 64'(bus1.rsp_data), 64'(sb1[0].data));
                void'(sb1.pop_front());
            end else begin
                check("rsp_idle1", 64'(bus1.rsp_valid), 64'd0);
            end

            check("ram_wren1", 64'(bus1.ram_wren), 64'(exp1_wren));
            if (exp1_wren) begin
                check("ram_addr1", 64'(bus1.ram_address), 64'(exp1_addr));
                check("ram_data1", 64'(bus1.ram_data), 64'(exp1_data));
            end

            if (g >= 0) begin
                g_addr = req_addr[g*AW +: AW];
                g_data = req_wdata[g*DW +: DW];
                check("ram_wren0", 64'(bus0.ram_wren), 64'(req_wren[g]));
                check("ram_addr0", 64'(bus0.ram_address), 64'(g_addr));
                if (req_wren[g]) begin
                    check("ram_data0", 64'(bus0.ram_data), 64'(g_data));
                    ref_mem[g_addr] = g_data;
                end else begin
                    ent.id   = g;
                    ent.data = ref_mem[g_addr];
                    ent.due  = cyc + 1;
                    sb0.push_back(ent);
                    ent.due  = cyc + 2;
                    sb1.push_back(ent);
                end
                exp1_wren = req_wren[g];
                exp1_addr = g_addr;
                exp1_data = g_data;
                mptr      = (g + 1) % N;
            end else begin
                check("ram_wren0_idle", 64'(bus0.ram_wren), 64'd0);
                exp1_wren = 1'b0;
            end
        end
    end

    // One request from requester id, held until accepted (bounded).
    task automatic issue(input int id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int budget;
        req_wren[id]          = wr;
        req_addr[id*AW +: AW] = a;
        req_wdata[id*DW +: DW] = d;
        req_valid[id]         = 1'b1;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!bus0.req_ready[id] && budget < 20);
        if (!bus0.req_ready[id]) check("issue_timeout", 64'(bus0.req_ready[id]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    // Raise a set of requesters; each drops as soon as it is accepted (bounded).
    task automatic serve(input logic [N-1:0] mask);
        logic [N-1:0] grant;
        int budget;
        req_valid = mask;
        budget = 0;
        while (req_valid != '0 && budget < 40) begin
            @(negedge clk);
            grant = bus0.req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~grant;
            budget++;
        end
        check("serve_drained", 64'(req_valid), 64'd0);
        req_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_wren  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(10'h010 + i);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Preload the addresses the read tests use.
        for (int i = 0; i < N; i++) issue(0, 1'b1, AW'(10'h010 + i), 32'h1000_0000 + 32'(i) * 32'h0111_1111);
        req_wren = '0;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(10'h010 + i);
        idle(3);

        // All four reading continuously from reset: order 0,1,2,3,0,1,2,3.
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        grant_log.delete();
        req_valid = 4'hF;
        idle(8);
        req_valid = '0;
        check("t2_grants", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check("t2_order", 64'(grant_log[i]), 64'(i % N));
        idle(4);

        // Write then read from requester 2.
        issue(2, 1'b1, 10'h055, 32'hDEAD_BEEF);
        issue(2, 1'b0, 10'h055, 32'h0);
        idle(4);

        // ptr=2 with requesters 1 and 3 pending: 3 first, then 1, ptr back to 2.
        issue(1, 1'b0, 10'h011, 32'h0);
        req_addr[2*AW +: AW] = 10'h012;
        req_wren = '0;
        grant_log.delete();
        serve(4'b1010);
        serve(4'b0110);
        check("t3_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() >= 3) begin
            check("t3_first", 64'(grant_log[0]), 64'd3);
            check("t3_second", 64'(grant_log[1]), 64'd1);
            check("t3_ptr_at_2", 64'(grant_log[2]), 64'd2);
        end
        idle(4);

        // Back-to-back write/read at the top address from requester 0.
        issue(0, 1'b1, 10'h3FF, 32'h1234_5678);
        issue(0, 1'b0, 10'h3FF, 32'h0);
        issue(0, 1'b1, 10'h3FF, 32'hCAFE_F00D);
        issue(0, 1'b0, 10'h3FF, 32'h0);
        idle(4);

        // Reset right after a read accept from requester 2 (ptr becomes 3).
        issue(2, 1'b0, 10'h012, 32'h0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(10'h010 + i);
        req_wren = '0;
        grant_log.delete();
        serve(4'hF);
        check("t5_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() > 0) check("t5_first_after_reset", 64'(grant_log[0]), 64'd0);
        idle(5);

        check("sb0_drained", 64'(sb0.size()), 64'd0);
        check("sb1_drained", 64'(sb1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
